// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle-latency instruction SRAM,
// and delivers (pc, instr, valid) to IF/ID with stall, redirect and a 1-entry skid buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              im_cs,
  output logic              im_oe,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_dout,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr_out,
  output logic              instr_valid
);

  logic [31:0] r_pc;
  logic        r_inflight_v;
  logic [31:0] r_inflight_pc;
  logic        r_skid_v;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic        r_instr_valid;

  logic        w_issue;
  logic [31:0] w_pc_next;
  logic        w_inflight_v_next;
  logic [31:0] w_inflight_pc_next;
  logic        w_skid_v_next;
  logic [31:0] w_skid_pc_next;
  logic [31:0] w_skid_instr_next;
  logic [31:0] w_pc_out_next;
  logic [31:0] w_instr_out_next;
  logic        w_instr_valid_next;

  // A pending skid entry never blocks issue: it drains in the same cycle the new fetch goes out.
  assign w_issue = !rst && !stall && !redirect;
  assign im_cs   = w_issue;
  assign im_oe   = w_issue;
  assign im_addr = r_pc[ADDR_W+1:2];

  assign pc_out      = r_pc_out;
  assign instr_out   = r_instr_out;
  assign instr_valid = r_instr_valid;

  always_comb begin
    w_pc_next          = r_pc;
    w_inflight_v_next  = w_issue;
    w_inflight_pc_next = w_issue ? r_pc : r_inflight_pc;
    w_skid_v_next      = r_skid_v;
    w_skid_pc_next     = r_skid_pc;
    w_skid_instr_next  = r_skid_instr;
    w_pc_out_next      = r_pc_out;
    w_instr_out_next   = r_instr_out;
    w_instr_valid_next = r_instr_valid;

    if (redirect) begin
      w_pc_next          = {redirect_pc[31:2], 2'b00};
      w_inflight_v_next  = 1'b0;
      w_skid_v_next      = 1'b0;
      w_pc_out_next      = 32'h0;
      w_instr_out_next   = 32'h0;
      w_instr_valid_next = 1'b0;
    end else if (stall) begin
      // Output holds; the one response that can be outstanding is parked in the skid.
      if (r_inflight_v) begin
        w_skid_v_next     = 1'b1;
        w_skid_pc_next    = r_inflight_pc;
        w_skid_instr_next = im_dout;
      end
    end else if (r_skid_v) begin
      w_skid_v_next      = 1'b0;
      w_pc_out_next      = r_skid_pc;
      w_instr_out_next   = r_skid_instr;
      w_instr_valid_next = 1'b1;
    end else if (r_inflight_v) begin
      w_pc_out_next      = r_inflight_pc;
      w_instr_out_next   = im_dout;
      w_instr_valid_next = 1'b1;
    end else begin
      w_pc_out_next      = 32'h0;
      w_instr_out_next   = 32'h0;
      w_instr_valid_next = 1'b0;
    end

    if (w_issue) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_skid_v      <= 1'b0;
      r_skid_pc     <= 32'h0;
      r_skid_instr  <= 32'h0;
      r_pc_out      <= 32'h0;
      r_instr_out   <= 32'h0;
      r_instr_valid <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_inflight_v  <= w_inflight_v_next;
      r_inflight_pc <= w_inflight_pc_next;
      r_skid_v      <= w_skid_v_next;
      r_skid_pc     <= w_skid_pc_next;
      r_skid_instr  <= w_skid_instr_next;
      r_pc_out      <= w_pc_out_next;
      r_instr_out   <= w_instr_out_next;
      r_instr_valid <= w_instr_valid_next;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random stall/redirect/reset traffic,
// checked every cycle against a transaction-level fetch model.
module tb_if_fetch_unit;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              im_cs;
  logic              im_oe;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_dout = 32'h0;
  logic [31:0]       pc_out;
  logic [31:0]       instr_out;
  logic              instr_valid;

  int checks = 0;
  int fails  = 0;

  // Model: PC of next fetch, issued-but-undelivered fetches, and the output register.
  logic [31:0] m_next_pc;
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;

  if_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .im_cs(im_cs), .im_oe(im_oe), .im_addr(im_addr), .im_dout(im_dout),
    .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // SRAM with mem[i] = A0000000 + i; returns garbage when not selected.
  always @(posedge clk) begin
    if (im_cs && im_oe) im_dout <= 32'hA000_0000 + {18'h0, im_addr};
    else                im_dout <= $urandom;
  end

  function automatic logic [31:0] mem_of(input logic [31:0] pc);
    return 32'hA000_0000 + {18'h0, pc[ADDR_W+1:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_next_pc = 32'h0;
    m_q.delete();
    m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, m_valid});
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".instr"}, instr_out, m_instr);
  endtask

  // One clock: drive inputs just after a negedge, check the SRAM request, advance, check outputs.
  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    logic issue;
    stall = s; redirect = r; redirect_pc = rp;
    #1;
    issue = !s && !r;
    chk("im_cs", {31'h0, im_cs}, {31'h0, issue});
    chk("im_oe", {31'h0, im_oe}, {31'h0, issue});
    chk("im_addr", {18'h0, im_addr}, {18'h0, m_next_pc[ADDR_W+1:2]});
    if (r) begin
      m_q.delete();
      m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      m_next_pc = rp & 32'hFFFF_FFFC;
    end else if (!s) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_front(); m_instr = mem_of(m_pc); m_valid = 1'b1;
      end else begin
        m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
      end
    end
    if (issue) begin
      m_q.push_back(m_next_pc);
      m_next_pc = m_next_pc + 32'd4;
    end
    @(posedge clk); #1;
    check_outputs("step");
    $display("cyc stall=%0b redir=%0b rpc=%h -> valid=%0b pc=%h instr=%h",
             s, r, rp, instr_valid, pc_out, instr_out);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.im_cs", {31'h0, im_cs}, 32'h0);
    check_outputs("rst.async");
    @(posedge clk); #1;
    check_outputs("rst.held");
    @(negedge clk);
    rst = 1'b0;
    $display("reset applied and released");
  endtask

  initial begin
    logic [31:0] rp;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: reset release and streaming
    step(0, 0, 0);
    chk("t1.first_valid", {31'h0, instr_valid}, 32'h0);
    step(0, 0, 0);
    chk("t1.pc0", pc_out, 32'h0); chk("t1.in0", instr_out, 32'hA000_0000);
    step(0, 0, 0);
    chk("t1.pc4", pc_out, 32'h4); chk("t1.in4", instr_out, 32'hA000_0001);

    // 2: stall with fetch of 8 in flight
    repeat (3) begin
      step(1, 0, 0);
      chk("t2.hold_pc", pc_out, 32'h4);
    end
    step(0, 0, 0);
    chk("t2.pc8", pc_out, 32'h8); chk("t2.in8", instr_out, 32'hA000_0002);
    step(0, 0, 0);
    chk("t2.pcC", pc_out, 32'hC); chk("t2.inC", instr_out, 32'hA000_0003);

    // 3: redirect to 0x40 with 0x10 in flight
    step(0, 1, 32'h40);
    chk("t3.valid0", {31'h0, instr_valid}, 32'h0); chk("t3.instr0", instr_out, 32'h0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t3.pc40", pc_out, 32'h40); chk("t3.in40", instr_out, 32'hA000_0010);

    // 4: redirect + stall with skid full
    step(0, 0, 0);
    step(1, 0, 0);
    step(1, 1, 32'h103);
    chk("t4.cleared", {31'h0, instr_valid}, 32'h0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t4.pc100", pc_out, 32'h100); chk("t4.in100", instr_out, 32'hA000_0040);

    // 5: wrap of the PC
    step(0, 1, 32'hFFFF_FFF8);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t5.pcF8", pc_out, 32'hFFFF_FFF8);
    step(0, 0, 0);
    chk("t5.pcFC", pc_out, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("t5.pc0", pc_out, 32'h0); chk("t5.in0", instr_out, 32'hA000_0000);

    // 6: reset mid-stream with skid full
    step(1, 0, 0);
    do_reset();
    step(0, 0, 0);
    chk("t6.first_pc", m_pc, pc_out);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel == 0) begin
        do_reset();
      end else begin
        case ($urandom_range(0, 3))
          0: rp = $urandom;
          1: rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          default: rp = $urandom & 32'h0000_FFFF;
        endcase
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, rp);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
